// File: rtl/rhythm_score_if.sv
// Bundle of note/key inputs and score/render outputs for rhythm_score_unit.
// master drives notes, keys and digit_sel; slave is the scoring engine.
interface rhythm_score_if #(
    parameter int NUM_LANES = 4,
    parameter int KEY_W     = 8,
    parameter int DIGITS    = 3
);
    localparam int LW = ($clog2(NUM_LANES) > 1) ? $clog2(NUM_LANES) : 1;

    logic                         note_start;
    logic [LW-1:0]                active_lane;
    logic [NUM_LANES*KEY_W-1:0]   lane_codes;
    logic                         key_valid;
    logic [KEY_W-1:0]             key_code;
    logic [2:0]                   digit_sel;
    logic [3:0]                   digit_out;
    logic [DIGITS*4-1:0]          score_bcd;
    logic [3:0]                   weight;
    logic                         hit;
    logic                         miss;
    logic [7:0]                   hit_count;
    logic                         game_over;

    modport master (
        output note_start, active_lane, lane_codes, key_valid, key_code, digit_sel,
        input  digit_out, score_bcd, weight, hit, miss, hit_count, game_over
    );

    modport slave (
        input  note_start, active_lane, lane_codes, key_valid, key_code, digit_sel,
        output digit_out, score_bcd, weight, hit, miss, hit_count, game_over
    );
endinterface

// File: rtl/rhythm_score_unit.sv
// Hit detection and BCD scoring for the rhythm game: matches held keys against
// the active lane's key code, weights hits by a decaying value, counts to game over.
module rhythm_score_unit #(
    parameter int NUM_LANES   = 4,
    parameter int KEY_W       = 8,
    parameter int DIGITS      = 3,
    parameter int WEIGHT_MAX  = 7,
    parameter int WEIGHT_MIN  = 1,
    parameter int DECAY_TICKS = 10444303,
    parameter int MAX_HITS    = 100
) (
    input  logic          clk,
    input  logic          reset,
    rhythm_score_if.slave bus
);
    localparam int LW    = ($clog2(NUM_LANES) > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W = $clog2(DECAY_TICKS);

    localparam logic [3:0]       W_MAX    = 4'(WEIGHT_MAX);
    localparam logic [3:0]       W_MIN    = 4'(WEIGHT_MIN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_TICKS - 1);
    localparam logic [7:0]       HITS_END = 8'(MAX_HITS);

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [3:0]                  weight_q, weight_d;
    logic [0:DIGITS-1][3:0]      score_q, score_d;
    logic [7:0]                  hit_count_q, hit_count_d;
    logic                        hit_q, hit_d;
    logic                        miss_q, miss_d;
    logic                        game_over_q, game_over_d;
    logic                        armed_q, armed_d;
    logic [3:0]                  digit_out_q, digit_out_d;

    logic [NUM_LANES-1:0]        lane_hit;
    logic                        match;
    logic                        evaluate;
    logic [0:DIGITS-1][3:0]      sum_bcd;
    logic [DIGITS:0]             carry;

    // Out-of-range lanes never equal any gi, so they can never match.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : gen_lane
            assign lane_hit[gi] = (bus.active_lane == LW'(gi)) &&
                                  (bus.key_code == bus.lane_codes[gi*KEY_W +: KEY_W]);
        end
    endgenerate

    assign match    = bus.key_valid && (|lane_hit);
    assign evaluate = armed_q && bus.key_valid && !game_over_q;

    // Decimal ripple adder: weight enters the least significant digit
    // (highest index); carry[0] out of the top digit means overflow.
    assign carry[DIGITS] = 1'b0;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : gen_digit
            logic [4:0] raw;
            if (gi == DIGITS - 1) begin : gen_lsd
                assign raw = {1'b0, score_q[gi]} + {1'b0, weight_q} + {4'd0, carry[gi+1]};
            end else begin : gen_upper
                assign raw = {1'b0, score_q[gi]} + {4'd0, carry[gi+1]};
            end
            assign carry[gi]   = (raw > 5'd9);
            assign sum_bcd[gi] = carry[gi] ? 4'(raw - 5'd10) : raw[3:0];
        end
    endgenerate

    always_comb begin
        cnt_d       = cnt_q;
        weight_d    = weight_q;
        score_d     = score_q;
        hit_count_d = hit_count_q;
        game_over_d = game_over_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        armed_d     = !bus.key_valid;
        digit_out_d = 4'd0;

        if (bus.note_start) begin
            cnt_d    = '0;
            weight_d = W_MAX;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            weight_d = (weight_q > W_MIN) ? weight_q - 4'd1 : weight_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // The sum above uses weight_q, i.e. the weight before any reload or decay.
        if (evaluate && match) begin
            hit_d       = 1'b1;
            score_d     = carry[0] ? {DIGITS{4'd9}} : sum_bcd;
            hit_count_d = hit_count_q + 8'd1;
            if (hit_count_q + 8'd1 == HITS_END) begin
                game_over_d = 1'b1;
            end
        end else if (evaluate) begin
            miss_d = 1'b1;
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (bus.digit_sel == 3'(i)) begin
                digit_out_d = score_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            weight_q    <= W_MAX;
            score_q     <= '0;
            hit_count_q <= 8'd0;
            game_over_q <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            armed_q     <= 1'b1;
            digit_out_q <= 4'd0;
        end else begin
            cnt_q       <= cnt_d;
            weight_q    <= weight_d;
            score_q     <= score_d;
            hit_count_q <= hit_count_d;
            game_over_q <= game_over_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            armed_q     <= armed_d;
            digit_out_q <= digit_out_d;
        end
    end

    assign bus.score_bcd = score_q;
    assign bus.weight    = weight_q;
    assign bus.hit_count = hit_count_q;
    assign bus.game_over = game_over_q;
    assign bus.hit       = hit_q;
    assign bus.miss      = miss_q;
    assign bus.digit_out = digit_out_q;

endmodule
